// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note-on/off events to VOICES slots,
// scanning one slot per cycle and stealing the oldest voice when all are busy.
module voice_allocator #(
  parameter int VOICES = 3,
  parameter int AGE_W  = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                EV_VALID,
  output logic                EV_READY,
  input  logic                EV_ON,
  input  logic [6:0]          EV_NOTE,
  input  logic                PANIC,
  output logic [8*VOICES-1:0] VOICE_NOTE,
  output logic [VOICES-1:0]   VOICE_GATE,
  output logic [VOICES-1:0]   VOICE_RETRIG,
  output logic [15:0]         STEAL_CNT
);

  localparam int               IDX_W    = $clog2(VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state_q, state_d;
  logic             ev_ready_q, ev_ready_d;
  logic             ev_on_q, ev_on_d;
  logic [6:0]       ev_note_q, ev_note_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             match_vld_q, match_vld_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic             free_vld_q, free_vld_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic [IDX_W-1:0] old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;

  logic [6:0]       note_q [VOICES];
  logic [6:0]       note_d [VOICES];
  logic [AGE_W-1:0] age_q  [VOICES];
  logic [AGE_W-1:0] age_d  [VOICES];
  logic [VOICES-1:0] gate_q, gate_d;
  logic [VOICES-1:0] retrig_q, retrig_d;
  logic [15:0]       steal_cnt_q, steal_cnt_d;

  logic [IDX_W-1:0] tgt_idx;
  logic             steal;

  always_comb begin
    state_d     = state_q;
    ev_ready_d  = ev_ready_q;
    ev_on_d     = ev_on_q;
    ev_note_d   = ev_note_q;
    idx_d       = idx_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    note_d      = note_q;
    age_d       = age_q;
    gate_d      = gate_q;
    retrig_d    = '0;
    steal_cnt_d = steal_cnt_q;

    // Retrigger beats free slot, free slot beats stealing the oldest voice.
    tgt_idx = old_idx_q;
    steal   = 1'b0;
    if (match_vld_q) begin
      tgt_idx = match_idx_q;
    end else if (free_vld_q) begin
      tgt_idx = free_idx_q;
    end else begin
      steal = 1'b1;
    end

    if (PANIC) begin
      state_d    = IDLE;
      ev_ready_d = 1'b0;
      gate_d     = '0;
      for (int i = 0; i < VOICES; i++) begin
        age_d[i] = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          ev_ready_d = 1'b1;
          if (EV_VALID && ev_ready_q) begin
            ev_ready_d  = 1'b0;
            ev_on_d     = EV_ON;
            ev_note_d   = EV_NOTE;
            idx_d       = '0;
            match_vld_d = 1'b0;
            match_idx_d = '0;
            free_vld_d  = 1'b0;
            free_idx_d  = '0;
            old_idx_d   = '0;
            old_age_d   = '0;
            state_d     = SCAN;
          end
        end
        SCAN: begin
          if (!match_vld_q && gate_q[idx_q] && (note_q[idx_q] == ev_note_q)) begin
            match_vld_d = 1'b1;
            match_idx_d = idx_q;
          end
          if (!free_vld_q && !gate_q[idx_q]) begin
            free_vld_d = 1'b1;
            free_idx_d = idx_q;
          end
          // Strict compare keeps the lowest index on age ties.
          if (age_q[idx_q] > old_age_q) begin
            old_idx_d = idx_q;
            old_age_d = age_q[idx_q];
          end
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        COMMIT: begin
          state_d    = IDLE;
          ev_ready_d = 1'b1;
          if (ev_on_q) begin
            for (int i = 0; i < VOICES; i++) begin
              if (IDX_W'(i) == tgt_idx) begin
                note_d[i]   = ev_note_q;
                gate_d[i]   = 1'b1;
                age_d[i]    = '0;
                retrig_d[i] = 1'b1;
              end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
              end
            end
            if (steal && (steal_cnt_q != 16'hFFFF)) begin
              steal_cnt_d = steal_cnt_q + 16'd1;
            end
          end else if (match_vld_q) begin
            // Note and age stay put so the oscillator holds its pitch on release.
            gate_d[match_idx_q] = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      ev_ready_q  <= 1'b0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      idx_q       <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      gate_q      <= '0;
      retrig_q    <= '0;
      steal_cnt_q <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ev_ready_q  <= ev_ready_d;
      ev_on_q     <= ev_on_d;
      ev_note_q   <= ev_note_d;
      idx_q       <= idx_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      gate_q      <= gate_d;
      retrig_q    <= retrig_d;
      steal_cnt_q <= steal_cnt_d;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= note_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_note_out
    assign VOICE_NOTE[8*gi +: 8] = {1'b0, note_q[gi]};
  end

  assign EV_READY     = ev_ready_q;
  assign VOICE_GATE   = gate_q;
  assign VOICE_RETRIG = retrig_q;
  assign STEAL_CNT    = steal_cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (VOICES=3): a reference model pushes the
// expected post-commit outputs to a scoreboard that is popped at each commit.
module tb_voice_allocator;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        EV_VALID = 1'b0;
  logic        EV_ON = 1'b0;
  logic [6:0]  EV_NOTE = '0;
  logic        PANIC = 1'b0;
  logic        EV_READY;
  logic [23:0] VOICE_NOTE;
  logic [2:0]  VOICE_GATE;
  logic [2:0]  VOICE_RETRIG;
  logic [15:0] STEAL_CNT;

  voice_allocator #(.VOICES(3), .AGE_W(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .EV_VALID     (EV_VALID),
    .EV_READY     (EV_READY),
    .EV_ON        (EV_ON),
    .EV_NOTE      (EV_NOTE),
    .PANIC        (PANIC),
    .VOICE_NOTE   (VOICE_NOTE),
    .VOICE_GATE   (VOICE_GATE),
    .VOICE_RETRIG (VOICE_RETRIG),
    .STEAL_CNT    (STEAL_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0] notes;
    logic [2:0]  gate;
    logic [2:0]  retrig;
    logic [15:0] steal;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [6:0] m_note [3];
  logic [2:0] m_gate;
  int         m_age  [3];
  int         m_steal;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pack_notes();
    logic [23:0] v;
    for (int i = 0; i < 3; i++) v[8*i +: 8] = {1'b0, m_note[i]};
    return v;
  endfunction

  function automatic void push_expected(input logic [2:0] retrig);
    exp_t e;
    e.notes  = pack_notes();
    e.gate   = m_gate;
    e.retrig = retrig;
    e.steal  = m_steal[15:0];
    sb_q.push_back(e);
  endfunction

  // Reference allocator: whole-array search, evaluated at once per event.
  function automatic void model_event(input logic on, input logic [6:0] n);
    int match = -1;
    int free  = -1;
    int old   = 0;
    int tgt;
    logic [2:0] rt = '0;
    for (int i = 0; i < 3; i++) begin
      if (match < 0 && m_gate[i] && m_note[i] == n) match = i;
      if (free < 0 && !m_gate[i]) free = i;
      if (m_age[i] > m_age[old]) old = i;
    end
    if (on) begin
      tgt = (match >= 0) ? match : (free >= 0) ? free : old;
      if (match < 0 && free < 0 && m_steal < 65535) m_steal++;
      for (int i = 0; i < 3; i++) begin
        if (i == tgt) begin
          m_note[i] = n;
          m_gate[i] = 1'b1;
          m_age[i]  = 0;
        end else if (m_gate[i] && m_age[i] < 15) begin
          m_age[i]++;
        end
      end
      rt[tgt] = 1'b1;
    end else if (match >= 0) begin
      m_gate[match] = 1'b0;
    end
    push_expected(rt);
  endfunction

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty observed_gate=%0h", tag, VOICE_GATE);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_note"},   VOICE_NOTE,   e.notes);
      check({tag, "_gate"},   VOICE_GATE,   e.gate);
      check({tag, "_retrig"}, VOICE_RETRIG, e.retrig);
      check({tag, "_steal"},  STEAL_CNT,    e.steal);
    end
  endtask

  // Called #1 after an edge. Accepts one event and checks the commit timing.
  task automatic send(input string tag, input logic on, input logic [6:0] n);
    int w = 0;
    while (EV_READY !== 1'b1 && w < 20) begin
      @(posedge CLK); #1;
      w++;
    end
    check({tag, "_ready_wait"}, EV_READY, 1'b1);
    model_event(on, n);
    EV_VALID = 1'b1;
    EV_ON    = on;
    EV_NOTE  = n;
    @(posedge CLK); #1;
    EV_VALID = 1'b0;
    EV_ON    = ~on;
    EV_NOTE  = ~n;
    check({tag, "_ready_busy"}, EV_READY, 1'b0);
    repeat (3) begin
      @(posedge CLK); #1;
      check({tag, "_retrig_scan"}, VOICE_RETRIG, 3'b000);
    end
    @(posedge CLK); #1;
    check({tag, "_ready_back"}, EV_READY, 1'b1);
    sb_check(tag);
    $display("event %s on=%0b note=%0d notes=%h gate=%b steal=%0d",
             tag, on, n, VOICE_NOTE, VOICE_GATE, STEAL_CNT);
    @(posedge CLK); #1;
    check({tag, "_retrig_one"}, VOICE_RETRIG, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_note[i] = '0;
      m_age[i]  = 0;
    end
    m_gate  = '0;
    m_steal = 0;

    // Reset release
    #50;
    check("rst_ready", EV_READY, 1'b0);
    check("rst_note",  VOICE_NOTE, 24'h0);
    check("rst_gate",  VOICE_GATE, 3'b000);
    check("rst_retrig", VOICE_RETRIG, 3'b000);
    check("rst_steal", STEAL_CNT, 16'h0);
    #50;
    RESET = 1'b1;
    #1;
    check("rst_ready_held", EV_READY, 1'b0);
    @(posedge CLK); #1;
    check("rst_ready_rise", EV_READY, 1'b1);

    // Fill all three slots
    send("on57", 1'b1, 7'd57);
    send("on69", 1'b1, 7'd69);
    send("on81", 1'b1, 7'd81);
    check("fill_notes", VOICE_NOTE, {8'd81, 8'd69, 8'd57});
    check("fill_gate",  VOICE_GATE, 3'b111);

    // Steal oldest (slot 0)
    send("steal60", 1'b1, 7'd60);
    check("steal_notes", VOICE_NOTE, {8'd81, 8'd69, 8'd60});
    check("steal_cnt",   STEAL_CNT, 16'd1);

    // Note-off, dropped note-off, retrigger
    send("off69", 1'b0, 7'd69);
    check("off69_gate", VOICE_GATE, 3'b101);
    check("off69_note", VOICE_NOTE[15:8], 8'd69);
    send("off99", 1'b0, 7'd99);
    check("off99_gate", VOICE_GATE, 3'b101);
    send("retrig81", 1'b1, 7'd81);
    check("retrig81_cnt", STEAL_CNT, 16'd1);

    // Free-slot reuse, then steal confirms slot 0 is oldest
    send("free45", 1'b1, 7'd45);
    check("free45_note", VOICE_NOTE[15:8], 8'd45);
    send("steal50", 1'b1, 7'd50);
    check("steal50_notes", VOICE_NOTE, {8'd81, 8'd45, 8'd50});
    check("steal50_cnt", STEAL_CNT, 16'd2);

    // PANIC mid-scan: note-on 70 accepted, PANIC sampled at E0+2
    check("panic_pre_ready", EV_READY, 1'b1);
    EV_VALID = 1'b1;
    EV_ON    = 1'b1;
    EV_NOTE  = 7'd70;
    @(posedge CLK); #1;
    EV_VALID = 1'b0;
    @(posedge CLK); #1;
    PANIC = 1'b1;
    m_gate = '0;
    for (int i = 0; i < 3; i++) m_age[i] = 0;
    push_expected(3'b000);
    @(posedge CLK); #1;
    PANIC = 1'b0;
    check("panic_ready_low", EV_READY, 1'b0);
    sb_check("panic");
    $display("event panic notes=%h gate=%b steal=%0d", VOICE_NOTE, VOICE_GATE, STEAL_CNT);
    @(posedge CLK); #1;
    check("panic_ready_back", EV_READY, 1'b1);
    repeat (5) begin
      @(posedge CLK); #1;
      check("panic_gate_hold", VOICE_GATE, 3'b000);
      check("panic_retrig_hold", VOICE_RETRIG, 3'b000);
    end

    // After PANIC all slots are free, so slot 0 is chosen
    send("on57b", 1'b1, 7'd57);
    check("on57b_notes", VOICE_NOTE, {8'd81, 8'd45, 8'd57});
    check("on57b_gate", VOICE_GATE, 3'b001);

    // Asynchronous reset mid-scan loses the event
    EV_VALID = 1'b1;
    EV_ON    = 1'b1;
    EV_NOTE  = 7'd99;
    @(posedge CLK); #1;
    EV_VALID = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    check("arst_note", VOICE_NOTE, 24'h0);
    check("arst_gate", VOICE_GATE, 3'b000);
    check("arst_steal", STEAL_CNT, 16'h0);
    check("arst_ready", EV_READY, 1'b0);
    @(posedge CLK); #2;
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("arst_ready_rise", EV_READY, 1'b1);
    repeat (6) @(posedge CLK);
    #1;
    check("arst_lost_gate", VOICE_GATE, 3'b000);
    check("arst_lost_note", VOICE_NOTE, 24'h0);
    $display("event reset_midscan notes=%h gate=%b", VOICE_NOTE, VOICE_GATE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
